ic0_cmd_master: RTL and testbench
=================================

// Module: ic0_cmd_master
// PURPOSE
//  Single-outstanding bus master for the ic0 interconnect; sits directly upstream of the ic0 slaves (GPIO and peers).
//  Accepts host commands over a valid/ready port and issues one-cycle wr/rd valid pulses with address and write data.
//  Reads: collects the slaves' OR-combined rd_ready and rd_data, then returns a response over a valid/ready port.
// PARAMETERS
//  N_SLV    4   number of slave read-return lanes (rd_ready/rd_data pairs)
//  TIMEOUT  16  read wait limit in cycles, counted from the cycle after ISSUE; must be >=1
// PORTS
//  clk                     in   1         clock; all logic on posedge
//  rst                     in   1         synchronous reset, active-high
//  cmd_valid               in   1         host command valid
//  cmd_ready               out  1         host command ready; high only in IDLE
//  cmd_write               in   1         1 = write, 0 = read
//  cmd_addr                in   32        byte address
//  cmd_wdata               in   32        write data; ignored on reads
//  rsp_valid               out  1         response valid
//  rsp_ready               in   1         response accept
//  rsp_rdata               out  32        read data; 0 for writes and on timeout
//  rsp_err                 out  1         timeout or multi-slave hit
//  ic0_c_axi_mst_wr_valid  out  1         one-cycle write strobe
//  ic0_c_axi_mst_rd_valid  out  1         one-cycle read strobe
//  ic0_axi_mst_wr_addr     out  32        write address (registered cmd_addr)
//  ic0_axi_mst_wr_data     out  32        write data (registered cmd_wdata)
//  ic0_axi_mst_rd_addr     out  32        read address (registered cmd_addr)
//  ic0_c_axi_slv_rd_ready  in   N_SLV     per-slave read-data-ready
//  ic0_axi_slv_rd_data     in   N_SLV*32  per-slave read data; lane i = [32*i +: 32]; a slave drives 0 when not ready
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high.
//  Reset values:
//   - all outputs 0 except cmd_ready = 1
//   - state IDLE; command registers and timer 0
//  FSM (states IDLE, ISSUE, WAIT_RD, RESP):
//   - IDLE: cmd_ready = 1. On cmd_valid: latch write/addr/wdata and go to ISSUE.
//   - ISSUE: exactly one cycle.
//     - Write: wr_valid = 1; go to RESP with rdata = 0, err = 0.
//     - Read: rd_valid = 1; sample readies. Any ready: capture and go to RESP. None: go to WAIT_RD with timer = 0.
//   - WAIT_RD: sample readies every cycle. Any ready: capture and go to RESP. Otherwise timer += 1.
//   - RESP: rsp_valid = 1; rdata and err held stable until rsp_ready, then go to IDLE.
//  Capture rules:
//   - rsp_rdata = OR of all lanes
//   - rsp_err = 1 if more than one ready bit is set in the capture cycle (data is still the OR)
//  Latency (handshake at cycle t):
//   - bus valid at t+1
//   - write rsp_valid at t+2
//   - read with slave ready at t+2 gives rsp_valid at t+3
//   - minimum cmd-to-cmd spacing is 3 cycles
//  Bus addr/data outputs hold their last command values between transactions and never glitch while valid is high.
//  Ready inputs in IDLE/RESP, or during ISSUE of a write, are ignored.
//  Timer width is $clog2(TIMEOUT+1) and saturates; it never wraps.
//  rst asserted in any state: next cycle IDLE, valids 0, any pending response is discarded.
// CONFIGURATION
//  Macro IC0_MST_TIMEOUT_EN:
//   - Defined: when the timer reaches TIMEOUT in WAIT_RD with no ready, go to RESP with rdata = 0, err = 1.
//     A ready and the timeout in the same cycle: the ready wins.
//   - Undefined: no timer logic; WAIT_RD waits indefinitely; rsp_err reports multi-hit only.
// STRUCTURE
//  Package ic0_bus_pkg holds:
//   - localparams IC0_AW = 32, IC0_DW = 32
//   - typedef enum ic0_mst_state_t {IDLE, ISSUE, WAIT_RD, RESP}
//   - typedef struct ic0_rsp_t {rdata, err}
//  Sub-module ic0_rd_collect (combinational) takes the N_SLV lanes and produces:
//   - any_ready, OR-reduced data, multi_hit
// TESTING
//  1. Write 0x444 data 0xF at t -> wr_valid = 1 only at t+1, wr_addr 0x444, wr_data 0xF; rsp_valid at t+2, err 0, rdata 0.
//  2. Read 0x460; ready[0] = 1 with data 0x5 at t+2 -> rd_valid at t+1, rd_addr 0x460; rsp at t+3, rdata 0x5, err 0.
//  3. With IC0_MST_TIMEOUT_EN, TIMEOUT = 16, read 0x800, no ready -> rsp_valid at t+18, rdata 0, err 1.
//     Without the macro, no rsp over 100 cycles.
//  4. rsp_ready held low 5 cycles -> rsp_valid, rdata, err stable; cmd_ready 0; no new bus valid; IDLE the cycle after acceptance.
//  5. Readies 0b0011, lane0 = 0x1, lane1 = 0x2 -> rdata 0x3, err 1.
//  6. rst pulsed in WAIT_RD -> next cycle IDLE, cmd_ready 1; a later stray ready gives no rsp_valid.

Source files
------------

// File: rtl/ic0_bus_pkg.sv
// Shared ic0 bus widths, master FSM state encoding and response payload.
package ic0_bus_pkg;

  localparam int unsigned IC0_AW = 32;
  localparam int unsigned IC0_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } ic0_mst_state_t;

  typedef struct packed {
    logic [IC0_DW-1:0] rdata;
    logic              err;
  } ic0_rsp_t;

endpackage

// File: rtl/ic0_rd_collect.sv
// Combines the per-slave read-return lanes: any-ready, OR of data, multi-hit.
module ic0_rd_collect
  import ic0_bus_pkg::*;
#(
  parameter int unsigned N_SLV = 4
) (
  input  logic [N_SLV-1:0]        rd_ready,
  input  logic [N_SLV*IC0_DW-1:0] rd_data,
  output logic                    any_ready,
  output logic [IC0_DW-1:0]       or_data,
  output logic                    multi_hit
);

  // Slaves drive 0 when idle, so a plain OR merges the lanes.
  always_comb begin
    or_data = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      or_data = or_data | rd_data[i*IC0_DW +: IC0_DW];
    end
  end

  assign any_ready = |rd_ready;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hit = |(rd_ready & (rd_ready - N_SLV'(1)));

endmodule

// File: rtl/ic0_cmd_master.sv
// Single-outstanding ic0 bus master: host command in, one-cycle bus strobe,
// read-return collection and host response.
// Optional feature macro: IC0_MST_TIMEOUT_EN (read wait timeout, err response).
module ic0_cmd_master
  import ic0_bus_pkg::*;
#(
  parameter int unsigned N_SLV   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [IC0_AW-1:0]       cmd_addr,
  input  logic [IC0_DW-1:0]       cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IC0_DW-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    ic0_c_axi_mst_wr_valid,
  output logic                    ic0_c_axi_mst_rd_valid,
  output logic [IC0_AW-1:0]       ic0_axi_mst_wr_addr,
  output logic [IC0_DW-1:0]       ic0_axi_mst_wr_data,
  output logic [IC0_AW-1:0]       ic0_axi_mst_rd_addr,
  input  logic [N_SLV-1:0]        ic0_c_axi_slv_rd_ready,
  input  logic [N_SLV*IC0_DW-1:0] ic0_axi_slv_rd_data
);

  logic              any_ready;
  logic              multi_hit;
  logic [IC0_DW-1:0] or_data;

  ic0_mst_state_t state;
  logic           cmd_write_q;
  ic0_rsp_t       rsp_q;

  ic0_rd_collect #(
    .N_SLV (N_SLV)
  ) u_rd_collect (
    .rd_ready  (ic0_c_axi_slv_rd_ready),
    .rd_data   (ic0_axi_slv_rd_data),
    .any_ready (any_ready),
    .or_data   (or_data),
    .multi_hit (multi_hit)
  );

`ifdef IC0_MST_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer;
  logic          timeout_hit;

  // Fires on the WAIT_RD cycle whose increment would bring the timer to TIMEOUT.
  assign timeout_hit = (timer >= TW'(TIMEOUT - 1));
`endif

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  // Master FSM with registered handshake, bus strobe and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      cmd_ready              <= 1'b1;
      cmd_write_q            <= 1'b0;
      rsp_valid              <= 1'b0;
      rsp_q                  <= '0;
      ic0_c_axi_mst_wr_valid <= 1'b0;
      ic0_c_axi_mst_rd_valid <= 1'b0;
      ic0_axi_mst_wr_addr    <= '0;
      ic0_axi_mst_wr_data    <= '0;
      ic0_axi_mst_rd_addr    <= '0;
`ifdef IC0_MST_TIMEOUT_EN
      timer                  <= '0;
`endif
    end else begin
      ic0_c_axi_mst_wr_valid <= 1'b0;
      ic0_c_axi_mst_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready   <= 1'b0;
            cmd_write_q <= cmd_write;
            if (cmd_write) begin
              ic0_c_axi_mst_wr_valid <= 1'b1;
              ic0_axi_mst_wr_addr    <= cmd_addr;
              ic0_axi_mst_wr_data    <= cmd_wdata;
            end else begin
              ic0_c_axi_mst_rd_valid <= 1'b1;
              ic0_axi_mst_rd_addr    <= cmd_addr;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_write_q) begin
            rsp_q.rdata <= '0;
            rsp_q.err   <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (any_ready) begin
            rsp_q.rdata <= or_data;
            rsp_q.err   <= multi_hit;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
`ifdef IC0_MST_TIMEOUT_EN
            timer <= '0;
`endif
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (any_ready) begin
            rsp_q.rdata <= or_data;
            rsp_q.err   <= multi_hit;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
`ifdef IC0_MST_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_q.rdata <= '0;
            rsp_q.err   <= 1'b1;
            rsp_valid   <= 1'b1;
            timer       <= TW'(TIMEOUT);
            state       <= RESP;
          end else if (timer != TW'(TIMEOUT)) begin
            timer <= timer + TW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ic0_cmd_master.sv
// Self-checking bench for ic0_cmd_master: vector table, corner sequences,
// randomized transactions checked against a behavioural model.
module tb_ic0_cmd_master;

  localparam int unsigned N_SLV   = 4;
  localparam int unsigned TIMEOUT = 16;
`ifdef IC0_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [31:0]           cmd_addr;
  logic [31:0]           cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  wr_valid;
  logic                  rd_valid;
  logic [31:0]           wr_addr;
  logic [31:0]           wr_data;
  logic [31:0]           rd_addr;
  logic [N_SLV-1:0]      slv_ready;
  logic [N_SLV*32-1:0]   slv_data;

  int total = 0;
  int bad   = 0;

  ic0_cmd_master #(
    .N_SLV   (N_SLV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_write              (cmd_write),
    .cmd_addr               (cmd_addr),
    .cmd_wdata              (cmd_wdata),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_rdata              (rsp_rdata),
    .rsp_err                (rsp_err),
    .ic0_c_axi_mst_wr_valid (wr_valid),
    .ic0_c_axi_mst_rd_valid (rd_valid),
    .ic0_axi_mst_wr_addr    (wr_addr),
    .ic0_axi_mst_wr_data    (wr_data),
    .ic0_axi_mst_rd_addr    (rd_addr),
    .ic0_c_axi_slv_rd_ready (slv_ready),
    .ic0_axi_slv_rd_data    (slv_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    int           d;        // cycles after the bus strobe cycle when readies appear
    logic [3:0]   mask;
    logic [127:0] lanes;
    int           hold;     // cycles rsp_ready is held low
    logic [31:0]  exp_rd;
    bit           exp_err;
    int           exp_lat;  // cycles from handshake to first rsp_valid
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lanes(input logic [3:0] mask, input logic [127:0] lanes);
    slv_ready = mask;
    for (int i = 0; i < 4; i++) begin
      slv_data[32*i +: 32] = mask[i] ? lanes[32*i +: 32] : 32'h0;
    end
  endtask

  // Behavioural expectation straight from the response rules.
  function automatic void model(input bit wr, input int d, input logic [3:0] mask,
                                input logic [127:0] lanes, output logic [31:0] rd,
                                output bit err, output int lat);
    rd  = 32'h0;
    err = 1'b0;
    if (wr) begin
      lat = 2;
    end else if (TO_EN && d > int'(TIMEOUT)) begin
      err = 1'b1;
      lat = 2 + int'(TIMEOUT);
    end else begin
      for (int i = 0; i < 4; i++) if (mask[i]) rd = rd | lanes[32*i +: 32];
      err = ($countones(mask) > 1);
      lat = 2 + d;
    end
  endfunction

  task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d, input logic [3:0] mask,
                         input logic [127:0] lanes, input int hold,
                         input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int k;
    bit extra;
    check({name, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    check({name, ".strobe"}, 32'({wr_valid, rd_valid}), wr ? 32'd2 : 32'd1);
    if (wr) check({name, ".bus"}, wr_addr ^ wr_data, addr ^ wdata);
    else    check({name, ".bus"}, rd_addr, addr);
    k = 1;
    extra = 1'b0;
    while (!rsp_valid && k < 60) begin
      if (k - 1 == d) drive_lanes(mask, lanes);
      else            drive_lanes(4'h0, 128'h0);
      step();
      k++;
      if (wr_valid || rd_valid) extra = 1'b1;
      if (wr && (wr_addr !== addr || wr_data !== wdata)) extra = 1'b1;
      if (!wr && rd_addr !== addr) extra = 1'b1;
    end
    drive_lanes(4'h0, 128'h0);
    check({name, ".latency"}, rsp_valid ? 32'(k) : 32'd0, 32'(exp_lat));
    check({name, ".rdata"}, rsp_rdata, exp_rd);
    check({name, ".err"}, 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      drive_lanes(4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      step();
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err ||
          cmd_ready !== 1'b0 || wr_valid || rd_valid) extra = 1'b1;
    end
    drive_lanes(4'h0, 128'h0);
    check({name, ".quiet_stable"}, 32'(extra), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({name, ".back_idle"}, 32'({rsp_valid, cmd_ready}), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  e_rd;
    bit           e_err;
    int           e_lat;
    int           cnt;
    bit           wr;
    int           d;
    logic [3:0]   mask;
    logic [127:0] lanes;

    vecs[0] = '{1'b1, 32'h444, 32'hF,    0, 4'h0, 128'h0, 0, 32'h0, 1'b0, 2};
    vecs[1] = '{1'b0, 32'h460, 32'h0,    1, 4'h1, {96'h0, 32'h5}, 0, 32'h5, 1'b0, 3};
    vecs[2] = '{1'b0, 32'h500, 32'h0,    0, 4'h4, {32'h0, 32'hABCD, 64'h0}, 0, 32'hABCD, 1'b0, 2};
    vecs[3] = '{1'b0, 32'h504, 32'h0,    1, 4'h3, {64'h0, 32'h2, 32'h1}, 0, 32'h3, 1'b1, 3};
    vecs[4] = '{1'b0, 32'h508, 32'h0,    4, 4'hF, {32'h8, 32'h4, 32'h2, 32'h1}, 0, 32'hF, 1'b1, 6};
    vecs[5] = '{1'b1, 32'h50C, 32'h1234, 0, 4'hF, {32'h8, 32'h4, 32'h2, 32'h1}, 0, 32'h0, 1'b0, 2};
    vecs[6] = '{1'b0, 32'h510, 32'h0,   16, 4'h8, {32'h1234, 96'h0}, 0, 32'h1234, 1'b0, 18};
    vecs[7] = '{1'b0, 32'h514, 32'h0,    2, 4'h2, {64'h0, 32'hCAFE, 32'h0}, 5, 32'hCAFE, 1'b0, 4};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    slv_ready = '0;
    slv_data  = '0;
    step();
    step();
    check("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset.valids", 32'({rsp_valid, wr_valid, rd_valid, rsp_err}), 32'd0);
    check("reset.data", rsp_rdata | wr_addr | wr_data | rd_addr, 32'd0);
    rst = 1'b0;
    step();

    // Vector table
    for (int v = 0; v < 8; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].d,
              vecs[v].mask, vecs[v].lanes, vecs[v].hold,
              vecs[v].exp_rd, vecs[v].exp_err, vecs[v].exp_lat);
    end
    // Held write response
    run_txn("wr_hold", 1'b1, 32'h600, 32'h55AA, 0, 4'h0, 128'h0, 5, 32'h0, 1'b0, 2);

    // Read with no slave answering
`ifdef IC0_MST_TIMEOUT_EN
    run_txn("timeout", 1'b0, 32'h800, 32'h0, 1000, 4'h0, 128'h0, 2, 32'h0, 1'b1, 18);
`else
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h800;
    step();
    cmd_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (rsp_valid) cnt++;
    end
    check("no_timeout.rsp_count", 32'(cnt), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("no_timeout.recover", 32'(cmd_ready), 32'd1);
`endif

    // Reset while waiting for read data, then a stray ready
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h900;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_wait.state", 32'({cmd_ready, rsp_valid, wr_valid, rd_valid}), 32'h8);
    drive_lanes(4'h1, {96'h0, 32'h77});
    step();
    drive_lanes(4'h0, 128'h0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) cnt++;
      step();
    end
    check("rst_wait.stray_rsp", 32'(cnt), 32'd0);
    check("rst_wait.cmd_ready", 32'(cmd_ready), 32'd1);

    // Randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom_range(0, 1));
      d     = int'($urandom_range(0, 20));
      mask  = wr ? 4'($urandom) : 4'($urandom_range(1, 15));
      lanes = {$urandom, $urandom, $urandom, $urandom};
      model(wr, d, mask, lanes, e_rd, e_err, e_lat);
      run_txn($sformatf("rnd%0d", n), wr, $urandom, $urandom, d, mask, lanes,
              int'($urandom_range(0, 3)), e_rd, e_err, e_lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
